// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite slave front end of the adder register file.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_DATA, RD_RESP} rd_state_t;

    localparam logic [5:0] REG_R0   = 6'h0;
    localparam logic [5:0] REG_R1   = 6'h1;
    localparam logic [5:0] REG_R2   = 6'h2;
    localparam logic [5:0] REG_R3   = 6'h3;
    localparam logic [5:0] REG_LEDS = 6'h4;

    // Word index is address bits [7:2]; anything at or past num_regs is unmapped.
    function automatic logic word_in_range(input logic [5:0] word, input int unsigned num_regs);
        return {26'd0, word} < num_regs;
    endfunction

endpackage

// File: rtl/axi_lite_rd_engine.sv
// AR/R channel engine: latches the read address, samples register-file data one cycle later,
// and holds the response until the master accepts it.
module axi_lite_rd_engine
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_live,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic              i_arvalid,
    output logic              o_arready,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_rresp,
    output logic              o_rvalid,
    input  logic              i_rready,
    output logic [ADDR_W-1:0] o_addr_rc,
    input  logic [DATA_W-1:0] i_data_rc
);

    rd_state_t         r_state;
    rd_state_t         w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rdata;
    resp_t             r_rresp;
    logic              w_ar_hs;
    logic              w_in_range;

    assign w_ar_hs    = (r_state == RD_IDLE) && i_live && i_arvalid;
    assign w_in_range = word_in_range(r_addr[7:2], NUM_REGS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= RD_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        o_arready = 1'b0;
        o_rvalid  = 1'b0;
        case (r_state)
            RD_IDLE: begin
                o_arready = i_live;
                if (w_ar_hs) w_next = RD_DATA;
            end
            RD_DATA: w_next = RD_RESP;
            RD_RESP: begin
                o_rvalid = 1'b1;
                if (i_rready) w_next = RD_IDLE;
            end
            default: w_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_rdata <= '0;
            r_rresp <= OKAY;
        end else begin
            if (w_ar_hs) r_addr <= i_araddr;
            if (r_state == RD_DATA) begin
                r_rdata <= w_in_range ? i_data_rc : '0;
                r_rresp <= w_in_range ? OKAY : SLVERR;
            end
        end
    end

    assign o_addr_rc = r_addr;
    assign o_rdata   = r_rdata;
    assign o_rresp   = r_rresp;

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave front end: turns AW/W/B into a one-cycle register-file write strobe
// and delegates AR/R to axi_lite_rd_engine. One write and one read outstanding at most.
module axi4_lite_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 5
) (
    input  logic                ACLK,
    input  logic                ARSTn,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [ADDR_W-1:0]   o_addr_wc,
    output logic [DATA_W-1:0]   o_data_wc,
    output logic                o_en_amba_write,
    output logic [ADDR_W-1:0]   o_addr_rc,
    input  logic [DATA_W-1:0]   i_data_rc
);

    wr_state_t           r_wr_state;
    wr_state_t           w_wr_next;
    logic                r_live;
    logic                r_aw_held;
    logic                r_w_held;
    logic [ADDR_W-1:0]   r_addr_wc;
    logic [DATA_W-1:0]   r_data_wc;
    logic [DATA_W/8-1:0] r_wstrb;
    resp_t               r_bresp;
    logic                w_awready;
    logic                w_wready;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_wr_ok;

    // r_live keeps every READY low while reset is asserted and until the first edge after release.
    assign w_awready = (r_wr_state == WR_IDLE) && r_live && !r_aw_held;
    assign w_wready  = (r_wr_state == WR_IDLE) && r_live && !r_w_held;
    assign w_aw_hs   = AWVALID && w_awready;
    assign w_w_hs    = WVALID && w_wready;
    assign w_wr_ok   = word_in_range(r_addr_wc[7:2], NUM_REGS) && (&r_wstrb);

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) r_wr_state <= WR_IDLE;
        else        r_wr_state <= w_wr_next;
    end

    always_comb begin
        w_wr_next       = r_wr_state;
        BVALID          = 1'b0;
        o_en_amba_write = 1'b0;
        case (r_wr_state)
            WR_IDLE: if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) w_wr_next = WR_EXEC;
            WR_EXEC: begin
                o_en_amba_write = w_wr_ok;
                w_wr_next       = WR_RESP;
            end
            WR_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_wr_next = WR_IDLE;
            end
            default: w_wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_addr_wc <= '0;
            r_data_wc <= '0;
            r_wstrb   <= '0;
            r_bresp   <= OKAY;
        end else begin
            r_live <= 1'b1;
            if (w_aw_hs) begin
                r_addr_wc <= AWADDR;
                r_aw_held <= 1'b1;
            end
            if (w_w_hs) begin
                r_data_wc <= WDATA;
                r_wstrb   <= WSTRB;
                r_w_held  <= 1'b1;
            end
            if (r_wr_state == WR_EXEC) r_bresp <= w_wr_ok ? OKAY : SLVERR;
            if ((r_wr_state == WR_RESP) && BREADY) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    assign AWREADY   = w_awready;
    assign WREADY    = w_wready;
    assign BRESP     = r_bresp;
    assign o_addr_wc = r_addr_wc;
    assign o_data_wc = r_data_wc;

    axi_lite_rd_engine #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd_engine (
        .i_clk     (ACLK),
        .i_rst_n   (ARSTn),
        .i_live    (r_live),
        .i_araddr  (ARADDR),
        .i_arvalid (ARVALID),
        .o_arready (ARREADY),
        .o_rdata   (RDATA),
        .o_rresp   (RRESP),
        .o_rvalid  (RVALID),
        .i_rready  (RREADY),
        .o_addr_rc (o_addr_rc),
        .i_data_rc (i_data_rc)
    );

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Scoreboard bench for axi4_lite_slave: expected strobes/responses are queued at stimulus time
// and compared by a negedge monitor when the DUT produces them.
module tb_axi4_lite_slave;

    logic        ACLK = 1'b0;
    logic        ARSTn = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b1;
    logic [31:0] o_addr_wc;
    logic [31:0] o_data_wc;
    logic        o_en_amba_write;
    logic [31:0] o_addr_rc;
    logic [31:0] i_data_rc;

    always #5 ACLK = ~ACLK;

    axi4_lite_slave #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .NUM_REGS (5)
    ) dut (
        .ACLK            (ACLK),
        .ARSTn           (ARSTn),
        .AWADDR          (AWADDR),
        .AWVALID         (AWVALID),
        .AWREADY         (AWREADY),
        .WDATA           (WDATA),
        .WSTRB           (WSTRB),
        .WVALID          (WVALID),
        .WREADY          (WREADY),
        .BRESP           (BRESP),
        .BVALID          (BVALID),
        .BREADY          (BREADY),
        .ARADDR          (ARADDR),
        .ARVALID         (ARVALID),
        .ARREADY         (ARREADY),
        .RDATA           (RDATA),
        .RRESP           (RRESP),
        .RVALID          (RVALID),
        .RREADY          (RREADY),
        .o_addr_wc       (o_addr_wc),
        .o_data_wc       (o_data_wc),
        .o_en_amba_write (o_en_amba_write),
        .o_addr_rc       (o_addr_rc),
        .i_data_rc       (i_data_rc)
    );

    // Register file stand-in, written only by the DUT strobe.
    logic [31:0] regs [0:7] = '{default: '0};
    always @(posedge ACLK) if (o_en_amba_write) regs[o_addr_wc[4:2]] <= o_data_wc;
    assign i_data_rc = (o_addr_rc[7:2] < 6'd5) ? regs[o_addr_rc[4:2]] : 32'hDEAD_BEEF;

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_exp_t;
    typedef struct packed { logic [31:0] data; logic [1:0] resp; } rd_exp_t;

    wr_exp_t     q_strobe [$];
    logic [1:0]  q_bresp  [$];
    rd_exp_t     q_read   [$];
    logic [31:0] shadow [0:7] = '{default: '0};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit ok;
        ok = (addr[7:2] < 6'd5) && (strb == 4'hF);
        if (ok) begin
            q_strobe.push_back('{addr: addr, data: data});
            shadow[addr[4:2]] = data;
        end
        q_bresp.push_back(ok ? 2'b00 : 2'b10);
    endtask

    task automatic push_read(input logic [31:0] addr);
        bit ok;
        ok = addr[7:2] < 6'd5;
        q_read.push_back('{data: ok ? shadow[addr[4:2]] : 32'h0, resp: ok ? 2'b00 : 2'b10});
    endtask

    int cyc = 0;
    int aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
    bit prev_bvalid = 1'b0, prev_rvalid = 1'b0;
    always @(posedge ACLK) cyc = cyc + 1;

    always @(negedge ACLK) begin
        int last_wr;
        wr_exp_t e;
        if (ARSTn) begin
            if (AWVALID && AWREADY) aw_cyc = cyc;
            if (WVALID && WREADY)   w_cyc  = cyc;
            if (ARVALID && ARREADY) ar_cyc = cyc;
            last_wr = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
            if (o_en_amba_write) begin
                if (q_strobe.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
                else begin
                    e = q_strobe.pop_front();
                    check("strobe_addr", o_addr_wc, e.addr);
                    check("strobe_data", o_data_wc, e.data);
                    check("strobe_latency", 32'(cyc - last_wr), 32'd1);
                end
            end
            if (BVALID) begin
                if (!prev_bvalid) check("bvalid_latency", 32'(cyc - last_wr), 32'd2);
                if (q_bresp.size() == 0) check("unexpected_bvalid", 32'd1, 32'd0);
                else begin
                    check("bresp", {30'd0, BRESP}, {30'd0, q_bresp[0]});
                    if (BREADY) void'(q_bresp.pop_front());
                end
            end
            if (RVALID) begin
                if (!prev_rvalid) check("rvalid_latency", 32'(cyc - ar_cyc), 32'd2);
                if (q_read.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    check("rdata", RDATA, q_read[0].data);
                    check("rresp", {30'd0, RRESP}, {30'd0, q_read[0].resp});
                    if (RREADY) void'(q_read.pop_front());
                end
            end
        end
        prev_bvalid = BVALID && ARSTn;
        prev_rvalid = RVALID && ARSTn;
    end

    task automatic drive_aw(input logic [31:0] addr, input int dly);
        bit got = 1'b0;
        @(posedge ACLK); #1;
        repeat (dly) begin @(posedge ACLK); #1; end
        AWADDR = addr; AWVALID = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge ACLK); got = AWREADY; end
        if (!got) check("aw_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1 AWVALID = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        bit got = 1'b0;
        @(posedge ACLK); #1;
        repeat (dly) begin @(posedge ACLK); #1; end
        WDATA = data; WSTRB = strb; WVALID = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge ACLK); got = WREADY; end
        if (!got) check("w_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1 WVALID = 1'b0;
    endtask

    task automatic drive_ar(input logic [31:0] addr);
        bit got = 1'b0;
        @(posedge ACLK); #1;
        ARADDR = addr; ARVALID = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge ACLK); got = ARREADY; end
        if (!got) check("ar_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1 ARVALID = 1'b0;
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int aw_dly, input int w_dly, input bit wait_b);
        fork
            drive_aw(addr, aw_dly);
            drive_w(data, strb, w_dly);
        join
        if (wait_b) begin
            for (int i = 0; i < 50 && q_bresp.size() != 0; i++) @(negedge ACLK);
            check("b_timeout", 32'(q_bresp.size()), 32'd0);
        end
    endtask

    task automatic drive_read(input logic [31:0] addr, input int rr_dly, input bit wait_r);
        if (rr_dly > 0) RREADY = 1'b0;
        drive_ar(addr);
        if (wait_r) begin
            if (rr_dly > 0) begin
                for (int i = 0; i < 20 && !RVALID; i++) @(negedge ACLK);
                repeat (rr_dly) @(posedge ACLK);
                #1 RREADY = 1'b1;
            end
            for (int i = 0; i < 50 && q_read.size() != 0; i++) @(negedge ACLK);
            check("r_timeout", 32'(q_read.size()), 32'd0);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly);
        push_write(addr, data, strb);
        drive_write(addr, data, strb, aw_dly, w_dly, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rr_dly);
        push_read(addr);
        drive_read(addr, rr_dly, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, {31'd0, AWREADY}, 32'd0);
        check({tag, "_wready"},  {31'd0, WREADY},  32'd0);
        check({tag, "_bvalid"},  {31'd0, BVALID},  32'd0);
        check({tag, "_bresp"},   {30'd0, BRESP},   32'd0);
        check({tag, "_arready"}, {31'd0, ARREADY}, 32'd0);
        check({tag, "_rvalid"},  {31'd0, RVALID},  32'd0);
        check({tag, "_rdata"},   RDATA,            32'd0);
        check({tag, "_rresp"},   {30'd0, RRESP},   32'd0);
        check({tag, "_addr_wc"}, o_addr_wc,        32'd0);
        check({tag, "_data_wc"}, o_data_wc,        32'd0);
        check({tag, "_strobe"},  {31'd0, o_en_amba_write}, 32'd0);
        check({tag, "_addr_rc"}, o_addr_rc,        32'd0);
    endtask

    initial begin
        #3 check_all_zero("reset");
        repeat (2) @(negedge ACLK);
        ARSTn = 1'b1;
        repeat (2) @(negedge ACLK);

        do_write(32'h04, 32'h7, 4'hF, 0, 0);
        fork
            do_write(32'h08, 32'hAA, 4'hF, 3, 0);
            begin repeat (3) @(negedge ACLK); check("wready_held", {31'd0, WREADY}, 32'd0); end
        join

        do_write(32'h14, 32'h33, 4'hF, 0, 0);
        do_write(32'h00, 32'h1, 4'hF, 0, 1);
        do_write(32'h00, 32'h55, 4'h3, 1, 0);
        do_read(32'h00, 0);

        do_write(32'h10, 32'h5, 4'hF, 0, 0);
        do_read(32'h10, 4);
        do_read(32'h20, 0);
        do_read(32'h08, 0);
        do_read(32'h04, 2);

        // Same-edge read and write of word 0: the read must see the pre-write value.
        push_read(32'h00);
        push_write(32'h00, 32'h9, 4'hF);
        fork
            drive_read(32'h00, 0, 1'b1);
            drive_write(32'h00, 32'h9, 4'hF, 0, 0, 1'b1);
        join
        do_read(32'h00, 0);

        BREADY = 1'b0;
        RREADY = 1'b0;
        push_write(32'h14, 32'h66, 4'hF);
        push_read(32'h04);
        fork
            drive_write(32'h14, 32'h66, 4'hF, 0, 0, 1'b0);
            drive_read(32'h04, 0, 1'b0);
        join
        for (int i = 0; i < 20 && !(BVALID && RVALID); i++) @(negedge ACLK);
        check("rst_setup", {31'd0, BVALID && RVALID}, 32'd1);
        #2 ARSTn = 1'b0;
        #1 check_all_zero("midrst");
        q_strobe.delete();
        q_bresp.delete();
        q_read.delete();
        repeat (2) @(negedge ACLK);
        ARSTn = 1'b1;
        BREADY = 1'b1;
        RREADY = 1'b1;
        repeat (3) @(negedge ACLK);
        check("post_awready", {31'd0, AWREADY}, 32'd1);
        check("post_wready",  {31'd0, WREADY},  32'd1);
        check("post_arready", {31'd0, ARREADY}, 32'd1);
        check("post_bvalid",  {31'd0, BVALID},  32'd0);
        check("post_rvalid",  {31'd0, RVALID},  32'd0);

        do_write(32'h0C, 32'h1234, 4'hF, 2, 0);
        do_read(32'h0C, 0);
        do_read(32'h00, 0);

        repeat (5) @(negedge ACLK);
        check("queues_drained", 32'(q_strobe.size() + q_bresp.size() + q_read.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
